// File: rtl/aon_counter_bank.sv
// aon_counter_bank: always-on EPC/sensor counter, flag and code stores with command-owned snapshot/commit transactions; optional store parity under AON_PARITY_EN
module aon_counter_bank #(
  parameter int NUM_SENS = 2,
  parameter int CW = 6,
  parameter int CODE_W = 16
) (
  input  logic                   clk,
  input  logic                   factory_reset,
  input  logic [13:0]            rx_cmd,
  input  logic                   packet_complete,
  input  logic                   tx_enable,
  input  logic                   ADC_data_ready,
  input  logic                   code_wr,
  input  logic [CODE_W-1:0]      code_in,
  input  logic                   inven_flag_in,
  input  logic                   sl_flag_in,
  input  logic [CW-1:0]          epc_cnt_in,
  input  logic [NUM_SENS*CW-1:0] sens_cnt_in,
  output logic [CW-1:0]          epc_cnt_out,
  output logic [NUM_SENS*CW-1:0] sens_cnt_out,
  output logic                   inven_flag_out,
  output logic                   sl_flag_out,
  output logic [CODE_W-1:0]      code_out,
  output logic                   busy,
  output logic                   commit_pulse,
  output logic                   parity_err
);
  typedef enum logic [1:0] {IDLE, SNAP, WAIT, COMMIT} state_t;
  typedef enum logic [2:0] {NONE, SEL, READ, SWR, EPCW, ACK} owner_t;
  state_t state, state_n;
  owner_t owner, owner_n;
  logic seen_tx, own_bit, exit_ok, snap, commit;
  logic wr_epc, wr_sens, wr_sel, wr_code;
  logic [CW-1:0] epc_st;
  logic [NUM_SENS*CW-1:0] sens_st;
  logic inven_st, sl_st;
  logic [CODE_W-1:0] code_st;
  assign snap = state == SNAP;
  assign commit = state == COMMIT;
  assign busy = state != IDLE;
  assign commit_pulse = commit;
  assign wr_epc = commit && owner == EPCW;
  assign wr_sens = commit && (owner == READ || owner == SWR);
  assign wr_sel = commit && owner == SEL;
  assign wr_code = code_wr || wr_sel;
  // owner's hold bit and WAIT exit condition
  always_comb begin
    own_bit = owner == SEL ? rx_cmd[4] : owner == READ ? rx_cmd[11] :
              owner == SWR ? rx_cmd[10] : owner == EPCW ? rx_cmd[8] : 1'b0;
    exit_ok = owner == SEL ? packet_complete : owner == READ ? seen_tx & ~tx_enable :
              owner == SWR ? packet_complete & ADC_data_ready : owner == EPCW ? packet_complete : 1'b0;
  end
  // next state and fixed-priority owner capture
  always_comb begin
    state_n = state;
    owner_n = owner;
    case (state)
      IDLE: if (|{rx_cmd[11], rx_cmd[10], rx_cmd[8], rx_cmd[4], rx_cmd[1]}) begin
        state_n = SNAP;
        owner_n = rx_cmd[8] ? EPCW : rx_cmd[10] ? SWR : rx_cmd[11] ? READ : rx_cmd[4] ? SEL : ACK;
      end
      SNAP: state_n = owner == ACK ? IDLE : WAIT;
      WAIT: state_n = exit_ok ? COMMIT : own_bit ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // FSM state, owner and tx_enable-seen-high tracking for the READ falling edge
  always_ff @(posedge clk or posedge factory_reset) begin
    if (factory_reset) begin
      state <= IDLE;
      owner <= NONE;
      seen_tx <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      seen_tx <= snap ? 1'b0 : seen_tx | (state == WAIT && tx_enable);
    end
  end
  // stores: written only on commit, code also on any code_wr
  always_ff @(posedge clk or posedge factory_reset) begin
    if (factory_reset) begin
      epc_st <= '0;
      sens_st <= '0;
      inven_st <= 1'b1;
      sl_st <= 1'b1;
      code_st <= '0;
    end else begin
      if (wr_epc) epc_st <= epc_cnt_in;
      if (wr_sens) sens_st <= sens_cnt_in;
      if (wr_sel) begin
        inven_st <= inven_flag_in;
        sl_st <= sl_flag_in;
      end
      if (wr_code) code_st <= code_in;
    end
  end
  // snapshot of the owner's stores, held until the next snapshot
  always_ff @(posedge clk or posedge factory_reset) begin
    if (factory_reset) begin
      epc_cnt_out <= '0;
      sens_cnt_out <= '0;
      inven_flag_out <= 1'b1;
      sl_flag_out <= 1'b1;
      code_out <= '0;
    end else if (snap) begin
      if (owner == SEL) begin
        inven_flag_out <= inven_st;
        sl_flag_out <= sl_st;
        code_out <= code_st;
      end
      if (owner == READ || owner == SWR) sens_cnt_out <= sens_st;
      if (owner == EPCW || owner == ACK) epc_cnt_out <= epc_st;
    end
  end
`ifdef AON_PARITY_EN
  logic epc_p, inven_p, sl_p, code_p, perr_hit;
  logic [NUM_SENS-1:0] sens_p, sens_bad;
  // even-parity bit per store word, tracking every store write
  always_ff @(posedge clk or posedge factory_reset) begin
    if (factory_reset) begin
      epc_p <= 1'b0;
      sens_p <= '0;
      inven_p <= 1'b1;
      sl_p <= 1'b1;
      code_p <= 1'b0;
    end else begin
      if (wr_epc) epc_p <= ^epc_cnt_in;
      if (wr_sens) for (int i = 0; i < NUM_SENS; i++) sens_p[i] <= ^sens_cnt_in[i*CW +: CW];
      if (wr_sel) begin
        inven_p <= inven_flag_in;
        sl_p <= sl_flag_in;
      end
      if (wr_code) code_p <= ^code_in;
    end
  end
  // recomputed parity per sensor word
  always_comb begin
    sens_bad = '0;
    for (int i = 0; i < NUM_SENS; i++) sens_bad[i] = ^{sens_st[i*CW +: CW], sens_p[i]};
  end
  assign perr_hit = snap && (owner == SEL ? (inven_st ^ inven_p) | (sl_st ^ sl_p) | (^{code_st, code_p}) :
                             (owner == READ || owner == SWR) ? |sens_bad :
                             (owner == EPCW || owner == ACK) ? ^{epc_st, epc_p} : 1'b0);
  // sticky parity error, cleared only by factory_reset
  always_ff @(posedge clk or posedge factory_reset) begin
    if (factory_reset) parity_err <= 1'b0;
    else if (perr_hit) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_aon_counter_bank.sv
// tb_aon_counter_bank: randomized and directed checks of aon_counter_bank against a transaction-level model
module tb_aon_counter_bank;
  localparam int NS = 2;
  localparam int CW = 6;
  localparam int CODE_W = 16;
  logic clk = 1'b0;
  logic factory_reset = 1'b1;
  logic [13:0] rx_cmd = '0;
  logic packet_complete = 1'b0, tx_enable = 1'b0, ADC_data_ready = 1'b0, code_wr = 1'b0;
  logic [CODE_W-1:0] code_in = '0;
  logic inven_flag_in = 1'b0, sl_flag_in = 1'b0;
  logic [CW-1:0] epc_cnt_in = '0;
  logic [NS*CW-1:0] sens_cnt_in = '0;
  logic [CW-1:0] epc_cnt_out;
  logic [NS*CW-1:0] sens_cnt_out;
  logic inven_flag_out, sl_flag_out, busy, commit_pulse, parity_err;
  logic [CODE_W-1:0] code_out;
  int total = 0, bad = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  aon_counter_bank #(.NUM_SENS(NS), .CW(CW), .CODE_W(CODE_W)) dut (
    .clk(clk), .factory_reset(factory_reset), .rx_cmd(rx_cmd),
    .packet_complete(packet_complete), .tx_enable(tx_enable), .ADC_data_ready(ADC_data_ready),
    .code_wr(code_wr), .code_in(code_in), .inven_flag_in(inven_flag_in), .sl_flag_in(sl_flag_in),
    .epc_cnt_in(epc_cnt_in), .sens_cnt_in(sens_cnt_in), .epc_cnt_out(epc_cnt_out),
    .sens_cnt_out(sens_cnt_out), .inven_flag_out(inven_flag_out), .sl_flag_out(sl_flag_out),
    .code_out(code_out), .busy(busy), .commit_pulse(commit_pulse), .parity_err(parity_err));
  task automatic check(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", n, $time, act, exp);
    end
  endtask
  // transaction-level model: stores, delivered snapshots, and the open transaction (owner = command bit)
  int m_epc, o_epc, m_code, o_code;
  int m_sens[NS], o_sens[NS];
  bit m_inv, m_sl, o_inv, o_sl, seen, fin;
  int phase, own;
  int prio[5] = '{8, 10, 11, 4, 1};
  always @(posedge clk or posedge factory_reset) begin
    if (factory_reset) begin
      m_epc = 0; o_epc = 0; m_code = 0; o_code = 0;
      foreach (m_sens[i]) begin m_sens[i] = 0; o_sens[i] = 0; end
      m_inv = 1; m_sl = 1; o_inv = 1; o_sl = 1;
      phase = 0; own = 0; seen = 0;
    end else begin
      case (phase)
        0: begin
          own = -1;
          foreach (prio[k]) if (own < 0 && rx_cmd[prio[k]]) own = prio[k];
          if (own >= 0) phase = 1;
        end
        1: begin
          if (own == 4) begin o_inv = m_inv; o_sl = m_sl; o_code = m_code; end
          else if (own == 10 || own == 11) o_sens = m_sens;
          else o_epc = m_epc;
          phase = (own == 1) ? 0 : 2;
          seen = 0;
        end
        2: begin
          fin = own == 4 ? packet_complete : own == 11 ? (seen && !tx_enable) :
                own == 10 ? (packet_complete && ADC_data_ready) : packet_complete;
          if (fin) phase = 3;
          else if (!rx_cmd[own]) phase = 0;
          else seen = seen | tx_enable;
        end
        default: begin
          if (own == 8) m_epc = epc_cnt_in;
          if (own == 10 || own == 11) foreach (m_sens[i]) m_sens[i] = int'(sens_cnt_in[i*CW +: CW]);
          if (own == 4) begin m_inv = inven_flag_in; m_sl = sl_flag_in; m_code = code_in; end
          phase = 0;
        end
      endcase
      if (code_wr) m_code = code_in;
    end
  end
  // every-cycle comparison of all outputs against the model
  always @(negedge clk) if (chk_en) begin
    check("epc_cnt_out", int'(epc_cnt_out), o_epc);
    for (int i = 0; i < NS; i++) check("sens_cnt_out", int'(sens_cnt_out[i*CW +: CW]), o_sens[i]);
    check("inven_flag_out", int'(inven_flag_out), int'(o_inv));
    check("sl_flag_out", int'(sl_flag_out), int'(o_sl));
    check("code_out", int'(code_out), o_code);
    check("busy", int'(busy), int'(phase != 0));
    check("commit_pulse", int'(commit_pulse), int'(phase == 3));
    check("parity_err", int'(parity_err), 0);
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic clr;
    rx_cmd = '0; packet_complete = 0; tx_enable = 0; ADC_data_ready = 0; code_wr = 0;
  endtask
  logic [CW-1:0] tmp;
  initial begin
    tick; tick;
    chk_en = 1;
    check("rst_epc", int'(epc_cnt_out), 0);
    check("rst_sens", int'(sens_cnt_out), 0);
    check("rst_inv", int'(inven_flag_out), 1);
    check("rst_sl", int'(sl_flag_out), 1);
    check("rst_code", int'(code_out), 0);
    check("rst_busy", int'(busy), 0);
    factory_reset = 0;
    rx_cmd = 14'h0002; tick;
    check("ack_busy", int'(busy), 1);
    check("ack_commit", int'(commit_pulse), 0);
    clr; tick;
    check("ack_busy_off", int'(busy), 0);
    check("ack_epc", int'(epc_cnt_out), 0);
    check("ack_inv", int'(inven_flag_out), 1);
    epc_cnt_in = 6'd3; rx_cmd = 14'h0100; tick; tick;
    packet_complete = 1; tick;
    check("epcw_commit", int'(commit_pulse), 1);
    clr; tick;
    check("epcw_commit_off", int'(commit_pulse), 0);
    rx_cmd = 14'h0002; tick; clr; tick;
    check("epcw_ack_epc", int'(epc_cnt_out), 3);
    sens_cnt_in = {6'd9, 6'd5}; rx_cmd = 14'h0800; tick; tick;
    tx_enable = 1; tick;
    check("read_no_commit", int'(commit_pulse), 0);
    tx_enable = 0; tick;
    check("read_commit", int'(commit_pulse), 1);
    clr; tick;
    rx_cmd = 14'h0800; tick; tick;
    check("read_sens", int'(sens_cnt_out), 12'h245);
    clr; tick;
    sens_cnt_in = {6'd33, 6'd17}; rx_cmd = 14'h0400; packet_complete = 1; tick; tick;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("swr_wait_commit", int'(commit_pulse), 0);
      check("swr_wait_busy", int'(busy), 1);
    end
    ADC_data_ready = 1; tick;
    check("swr_commit", int'(commit_pulse), 1);
    clr; tick;
    inven_flag_in = 0; sl_flag_in = 0; rx_cmd = 14'h0010; tick; tick;
    rx_cmd = 14'h0000; tick;
    check("sel_abort_busy", int'(busy), 0);
    check("sel_abort_commit", int'(commit_pulse), 0);
    code_in = 16'hBEEF; code_wr = 1; tick; clr;
    rx_cmd = 14'h0010; tick; tick;
    check("sel_inv", int'(inven_flag_out), 1);
    check("sel_sl", int'(sl_flag_out), 1);
    check("sel_code", int'(code_out), 16'hBEEF);
    clr; tick;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 15) begin
        case ($urandom_range(9))
          4: rx_cmd = 14'h0002;
          5: rx_cmd = 14'h0010;
          6: rx_cmd = 14'h0100;
          7: rx_cmd = 14'h0400;
          8: rx_cmd = 14'h0800;
          9: rx_cmd = 14'($urandom);
          default: rx_cmd = '0;
        endcase
      end
      packet_complete = $urandom_range(3) == 0;
      tx_enable = 1'($urandom_range(1));
      ADC_data_ready = $urandom_range(2) == 0;
      code_wr = $urandom_range(15) == 0;
      code_in = CODE_W'($urandom);
      inven_flag_in = 1'($urandom);
      sl_flag_in = 1'($urandom);
      epc_cnt_in = CW'($urandom);
      sens_cnt_in = (NS*CW)'($urandom);
      factory_reset = $urandom_range(299) == 0;
      tick;
    end
    factory_reset = 0; clr; tick; tick;
`ifdef AON_PARITY_EN
    chk_en = 0;
    tmp = dut.epc_st ^ 6'd1;
    force dut.epc_st = tmp; tick; release dut.epc_st;
    rx_cmd = 14'h0002; tick; clr; tick;
    check("perr_set", int'(parity_err), 1);
    tick; tick; tick;
    check("perr_sticky", int'(parity_err), 1);
    factory_reset = 1; tick;
    check("perr_clear", int'(parity_err), 0);
    factory_reset = 0; tick;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
